// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants
package riscv_pkg;
  typedef enum logic [1:0] {RUN, HALT, FAULT} fetch_state_t;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: combinational next-pc / next-state selection for the fetch stage
// Ports: pc_i/state_i current registers; inst_valid_i/inst_ready_i output handshake;
//        redirect_valid_i/redirect_target_i branch resolution; pc_d_o/state_d_o next values;
//        adv_o capture a new instruction; flush_o drop the held instruction.
module pc_next_logic
  import riscv_pkg::*;
#(
  parameter int s = 32,
  parameter logic [s-1:0] PC_LIMIT = s'(64)
) (
  input  logic [s-1:0]  pc_i,
  input  fetch_state_t  state_i,
  input  logic          inst_valid_i,
  input  logic          inst_ready_i,
  input  logic          redirect_valid_i,
  input  logic [s-1:0]  redirect_target_i,
  output logic [s-1:0]  pc_d_o,
  output fetch_state_t  state_d_o,
  output logic          adv_o,
  output logic          flush_o
);
  logic [s:0] pc_inc;
  logic run, redir, misaligned, beyond, limit_hit;
  // one extra bit so a limit at the top of the address space still halts instead of wrapping
  assign pc_inc = {1'b0, pc_i} + (s+1)'(PC_STEP);
  assign limit_hit = pc_inc > {1'b0, PC_LIMIT};
  assign run = state_i == RUN;
  assign redir = run && redirect_valid_i;
  assign misaligned = redir && |redirect_target_i[1:0];
  assign beyond = redir && !misaligned && redirect_target_i > PC_LIMIT;
  assign adv_o = run && (!inst_valid_i || inst_ready_i) && !redirect_valid_i;
  assign flush_o = redir;
  // faulting or out-of-range redirects leave pc alone so memory never sees a bad address
  assign pc_d_o = (redir && !misaligned && !beyond) ? redirect_target_i
                : (adv_o && !limit_hit) ? pc_inc[s-1:0] : pc_i;
  assign state_d_o = misaligned ? FAULT
                   : (beyond || (adv_o && limit_hit)) ? HALT : state_i;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and registered fetch stage toward decode
// Ports: clk/reset sync active-high; pcpresent -> inst_memory, instruction_in <- inst_memory;
//        redirect_valid/redirect_target from branch resolution;
//        inst_out/pc_out/pc_plus4_out/inst_valid + inst_ready handshake to decode;
//        halted/fault_misaligned sticky status, cleared only by reset.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int s = 32,
  parameter logic [s-1:0] RESET_PC = s'(DEFAULT_RESET_PC),
  parameter logic [s-1:0] PC_LIMIT = s'(64)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [s-1:0] pcpresent,
  input  logic [s-1:0] instruction_in,
  input  logic         redirect_valid,
  input  logic [s-1:0] redirect_target,
  output logic [s-1:0] inst_out,
  output logic [s-1:0] pc_out,
  output logic [s-1:0] pc_plus4_out,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic         halted,
  output logic         fault_misaligned
);
  fetch_state_t state_q, state_d;
  logic [s-1:0] pc_q, pc_d;
  logic adv, flush;
  pc_next_logic #(.s(s), .PC_LIMIT(PC_LIMIT)) u_next (
    .pc_i(pc_q),
    .state_i(state_q),
    .inst_valid_i(inst_valid),
    .inst_ready_i(inst_ready),
    .redirect_valid_i(redirect_valid),
    .redirect_target_i(redirect_target),
    .pc_d_o(pc_d),
    .state_d_o(state_d),
    .adv_o(adv),
    .flush_o(flush)
  );
  assign pcpresent = pc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      state_q <= RUN;
      inst_out <= '0;
      pc_out <= '0;
      pc_plus4_out <= s'(PC_STEP);
      inst_valid <= 1'b0;
      halted <= 1'b0;
      fault_misaligned <= 1'b0;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
      halted <= state_d == HALT;
      fault_misaligned <= state_d == FAULT;
      // outside RUN nothing is captured, so the last instruction drains on acceptance
      inst_valid <= !flush && (adv || (inst_valid && !inst_ready));
      if (adv) begin
        inst_out <= instruction_in;
        pc_out <= pc_q;
        pc_plus4_out <= pc_q + s'(PC_STEP);
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized check of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;
  localparam logic [31:0] LIMIT = 32'd64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] pcpresent, instruction_in, redirect_target = '0;
  logic [31:0] inst_out, pc_out, pc_plus4_out;
  logic redirect_valid = 1'b0, inst_ready = 1'b0;
  logic inst_valid, halted, fault_misaligned;
  logic [31:0] mem [32];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_pc, m_inst, m_pcout, m_p4;
  logic m_valid, m_halt, m_fault;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .pcpresent(pcpresent), .instruction_in(instruction_in),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_out(inst_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .halted(halted), .fault_misaligned(fault_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd128) ? mem[a[6:2]] : 32'h0;
  endfunction

  always_comb instruction_in = mem_word(pcpresent);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: advance one clock from the rules, then compare every output
  task automatic step(input logic rst, input logic rv, input logic [31:0] rt, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_target = rt; inst_ready = rdy;
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_inst = 0; m_pcout = 0; m_p4 = 4; m_valid = 0; m_halt = 0; m_fault = 0;
    end else if (m_halt || m_fault) begin
      if (m_valid && rdy) m_valid = 0;
    end else if (rv) begin
      m_valid = 0;
      if (rt % 4 != 0) m_fault = 1;
      else if (rt > LIMIT) m_halt = 1;
      else m_pc = rt;
    end else if (!m_valid || rdy) begin
      m_inst = mem_word(m_pc); m_pcout = m_pc; m_p4 = m_pc + 4; m_valid = 1;
      if (longint'(m_pc) + 4 > longint'(LIMIT)) m_halt = 1;
      else m_pc = m_pc + 4;
    end
    #1;
    chk("pcpresent", pcpresent, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fault_misaligned", 32'(fault_misaligned), 32'(m_fault));
    chk("inst_out", inst_out, m_inst);
    chk("pc_out", pc_out, m_pcout);
    chk("pc_plus4_out", pc_plus4_out, m_p4);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h002081B3;
    mem[1] = 32'h403202B3;
    mem[12] = 32'h00110293;
    mem[16] = 32'h002102E7;
    step(1, 0, 0, 0);
    chk("lit reset pcpresent", pcpresent, 32'h0);
    chk("lit reset pc_plus4", pc_plus4_out, 32'h4);
    chk("lit reset valid", 32'(inst_valid), 32'h0);
    step(0, 0, 0, 1);
    chk("lit c1 inst", inst_out, 32'h002081B3);
    chk("lit c1 pc_out", pc_out, 32'h0);
    chk("lit c1 pc_plus4", pc_plus4_out, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("lit stall inst", inst_out, 32'h002081B3);
      chk("lit stall pcpresent", pcpresent, 32'h4);
    end
    step(0, 0, 0, 1);
    chk("lit c2 inst", inst_out, 32'h403202B3);
    chk("lit c2 pc_out", pc_out, 32'h4);
    step(0, 0, 0, 1);
    chk("lit c3 pc_out", pc_out, 32'h8);
    step(0, 1, 32'd48, 0);
    chk("lit redir valid", 32'(inst_valid), 32'h0);
    chk("lit redir pcpresent", pcpresent, 32'd48);
    step(0, 0, 0, 1);
    chk("lit redir inst", inst_out, 32'h00110293);
    chk("lit redir pc_out", pc_out, 32'd48);
    step(0, 1, 32'd50, 1);
    chk("lit fault flag", 32'(fault_misaligned), 32'h1);
    chk("lit fault valid", 32'(inst_valid), 32'h0);
    chk("lit fault pcpresent", pcpresent, 32'd52);
    step(0, 1, 32'd0, 1);
    chk("lit fault ignore", pcpresent, 32'd52);
    step(1, 0, 0, 1);
    chk("lit fault cleared", 32'(fault_misaligned), 32'h0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1);
    chk("lit end pc_out", pc_out, 32'd64);
    chk("lit end inst", inst_out, 32'h002102E7);
    chk("lit end valid", 32'(inst_valid), 32'h1);
    chk("lit end halted", 32'(halted), 32'h1);
    step(0, 0, 0, 1);
    chk("lit drained valid", 32'(inst_valid), 32'h0);
    chk("lit halt pcpresent", pcpresent, 32'd64);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 1, 32'd48, 0);
    chk("lit rst pcpresent", pcpresent, 32'h0);
    chk("lit rst valid", 32'(inst_valid), 32'h0);
    chk("lit rst halted", 32'(halted), 32'h0);
    step(0, 0, 0, 1);
    chk("lit restart pc_out", pc_out, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = 32'($urandom_range(0, 21)) * 4;
      if ($urandom_range(0, 7) == 0) t = t + 32'($urandom_range(1, 3));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0, t, $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of inst_memory. Owns the program counter and drives pcpresent into the combinational instruction memory.
- Registers the returned instruction together with its PC into a valid/ready output toward decode.
- Accepts redirects from branch/jal/jalr resolution.
- Detects misaligned targets and end-of-program, and stops fetching in either case.

Parameters:
- s, 32, data/address width (matches inst_memory)
- RESET_PC, 0, PC value loaded on reset
- PC_LIMIT, 64, highest valid instruction byte address; any fetch beyond it halts

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pcpresent  output  s  address to inst_memory; equals internal PC register
- instruction_in  input  s  instruction from inst_memory, combinational from pcpresent
- redirect_valid  input  1  taken branch/jump this cycle
- redirect_target  input  s  byte address of the redirect
- inst_out  output  s  registered instruction to decode
- pc_out  output  s  PC of inst_out
- pc_plus4_out  output  s  pc_out+4, the link value for jal/jalr
- inst_valid  output  1  inst_out/pc_out hold a live instruction
- inst_ready  input  1  decode accepts when inst_valid && inst_ready
- halted  output  1  sticky; fetch stopped at end of program
- fault_misaligned  output  1  sticky; redirect_target[1:0] != 0

Behaviour:
- Reset (synchronous, any cycle, including mid-stall or mid-redirect) takes effect at the next rising edge:
  - pc = RESET_PC; inst_out = 0; pc_out = 0; pc_plus4_out = 4; inst_valid = 0; halted = 0; fault_misaligned = 0; state = RUN.
- States:
  - RUN: fetching.
  - HALT: halted = 1; no fetch; inst_valid drops once the last instruction is accepted.
  - FAULT: fault_misaligned = 1; inst_valid forced to 0 at the next edge.
  - HALT and FAULT are left only by reset.
- Advance condition: adv = (state == RUN) && (!inst_valid || inst_ready) && !redirect_valid.
- On adv (1-cycle latency, PC to registered output):
  - inst_out <= instruction_in; pc_out <= pc; pc_plus4_out <= pc+4; inst_valid <= 1; pc <= pc+4.
  - If pc+4 > PC_LIMIT: state <= HALT after this capture. The instruction at PC_LIMIT is still delivered.
- Backpressure: inst_valid && !inst_ready && !redirect_valid → pc, inst_out, pc_out and inst_valid all hold.
- Redirect (highest priority below reset, overrides stall):
  - Valid target: inst_valid <= 0 (flushes the held or in-flight instruction) and pc <= redirect_target. The next cycle fetches the target normally.
  - target[1:0] != 0: state <= FAULT; pc unchanged.
  - target > PC_LIMIT (aligned): state <= HALT.
  - Redirect in HALT/FAULT: ignored.
- Simultaneous redirect_valid && inst_ready with inst_valid: the current instruction counts as accepted; the redirect still flushes fetch.
- Arithmetic: pc+4 wraps modulo 2^s. PC_LIMIT normally fires first; if PC_LIMIT = 2^s-4, the halt is still taken, with no wrap to 0.
- pcpresent is combinational from the pc register only, never from redirect inputs, so there is no comb path redirect→memory.

Decomposition:
- Shared package riscv_pkg:
  - fetch_state_t enum {RUN, HALT, FAULT}
  - PC_STEP = 4
  - default RESET_PC
- One natural sub-module, pc_next_logic (combinational): selects next pc and next state from pc, adv, redirect_valid/target and PC_LIMIT, and flags misalignment/limit. The top holds the registers and handshake.

Test Plan:
- Reset, then inst_ready=1 held: cycle 1 inst_out=32'h002081B3, pc_out=0, pc_plus4_out=4. Cycle 2 inst_out=32'h403202B3, pc_out=4. Cycle 3 pc_out=8.
- After the first instruction is valid, inst_ready=0 for 3 cycles → inst_out stays 32'h002081B3, pcpresent stays 4. Release → next inst_out=32'h403202B3 with no skipped or duplicated PC.
- Redirect to 48 while pc_out=8 is valid and stalled → next cycle inst_valid=0, pcpresent=48. Following cycle inst_out=32'h00110293, pc_out=48. The pc=12 instruction is never presented.
- Redirect target 50 → fault_misaligned=1 next cycle, inst_valid=0, pcpresent frozen. A later redirect to 0 is ignored. Reset clears the fault.
- Sequential run to end → pc_out=64 delivered with inst_out=32'h002102E7, then halted=1 and inst_valid=0 after acceptance. pcpresent never advances to 68.
- Reset asserted during a stalled valid instruction plus a simultaneous redirect → next edge: pc=0, inst_valid=0, halted=0. Fetch restarts at pc_out=0.
